etapa_fetch: RTL and testbench

Instruction-fetch stage of the vector processor. Owns the program counter, drives a synchronous-read instruction memory, and presents 14-bit instructions with PC and valid flag to the IF/ID pipeline register. Supports stall from decode (one-entry skid buffer so no fetched word is lost), branch redirect with flush, and a terminal HALT state.

---
 rtl/etapa_fetch.sv | 101 ++++++++++
 tb/tb_etapa_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction memory
// and feeds the IF/ID register, with a one-entry skid buffer for decode stalls.
module etapa_fetch #(
   parameter int                  PC_WIDTH    = 8,
   parameter int                  INSTR_WIDTH = 14,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic [INSTR_WIDTH-1:0] instruction_out,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic                   valid_out,
   output logic                   halted
);

   typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

   state_t                 state;
   logic [PC_WIDTH-1:0]    pc;
   logic [PC_WIDTH-1:0]    pc_q;
   logic                   pend_valid;
   logic [INSTR_WIDTH-1:0] hold_instr;
   logic [PC_WIDTH-1:0]    hold_pc;
   logic                   hold_valid;

   logic [INSTR_WIDTH-1:0] sel_instr;
   logic [PC_WIDTH-1:0]    sel_pc;
   logic                   sel_valid;
   logic                   sel_is_halt;

   assign imem_addr = pc;

   // The skid word, when present, is always older than the word on imem_data.
   always_comb begin
      sel_instr = imem_data;
      sel_pc    = pc_q;
      sel_valid = pend_valid;
      if (hold_valid) begin
         sel_instr = hold_instr;
         sel_pc    = hold_pc;
         sel_valid = 1'b1;
      end
      sel_is_halt = sel_valid && (sel_instr[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= RUN;
         pc              <= RESET_PC;
         pc_q            <= '0;
         pend_valid      <= 1'b0;
         hold_instr      <= '0;
         hold_pc         <= '0;
         hold_valid      <= 1'b0;
         instruction_out <= '0;
         pc_out          <= '0;
         valid_out       <= 1'b0;
         halted          <= 1'b0;
      end else if (state == HALT) begin
         instruction_out <= '0;
         valid_out       <= 1'b0;
         halted          <= 1'b1;
      end else if (branch_taken) begin
         pc              <= branch_target;
         pend_valid      <= 1'b0;
         hold_valid      <= 1'b0;
         instruction_out <= '0;
         valid_out       <= 1'b0;
         state           <= RUN;
      end else if (stall) begin
         if (state == RUN) begin
            if (pend_valid && !hold_valid) begin
               hold_instr <= imem_data;
               hold_pc    <= pc_q;
               hold_valid <= 1'b1;
            end
            pc_q       <= pc;
            pend_valid <= 1'b1;
            state      <= STALL;
         end
      end else begin
         instruction_out <= sel_valid ? sel_instr : '0;
         pc_out          <= sel_pc;
         valid_out       <= sel_valid;
         hold_valid      <= 1'b0;
         pc_q            <= pc;
         pc              <= pc + PC_WIDTH'(1);
         // Leaving a stall with an empty skid presents mem[pc] now; the memory re-reads
         // the same address this edge, so that next arrival is a duplicate to drop.
         pend_valid      <= !(state == STALL && !hold_valid);
         state           <= sel_is_halt ? HALT : RUN;
      end
   end

endmodule

// File: tb/tb_etapa_fetch.sv
// Bench for etapa_fetch: behavioural synchronous memory plus a queue of expected
// {pc, instruction} pairs consumed as the fetch stage presents words.
module tb_etapa_fetch;
   localparam int PW = 8;
   localparam int IW = 14;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, stall, branch_taken;
   logic [PW-1:0] branch_target, imem_addr, pc_out;
   logic [IW-1:0] imem_data, instruction_out;
   logic          valid_out, halted;

   logic          rst_n2;
   logic [PW-1:0] imem_addr2, pc_out2;
   logic [IW-1:0] imem_data2, instruction_out2;
   logic          valid_out2, halted2;

   logic [IW-1:0] mem [256];

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [PW-1:0] pc;
      logic [IW-1:0] instr;
   } exp_t;
   exp_t sb[$];

   etapa_fetch dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
      .instruction_out(instruction_out), .pc_out(pc_out), .valid_out(valid_out),
      .halted(halted)
   );

   etapa_fetch #(.RESET_PC(8'hFE)) dut_wrap (
      .clk(clk), .rst_n(rst_n2), .stall(1'b0), .branch_taken(1'b0),
      .branch_target(8'h00), .imem_addr(imem_addr2), .imem_data(imem_data2),
      .instruction_out(instruction_out2), .pc_out(pc_out2), .valid_out(valid_out2),
      .halted(halted2)
   );

   always @(posedge clk) begin
      imem_data  <= mem[imem_addr];
      imem_data2 <= 14'h200 + {6'b0, imem_addr2};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [PW-1:0] pc, input logic [IW-1:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      sb.delete();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic run_until(input logic [PW-1:0] target);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(valid_out === 1'b1 && pc_out === target) && n < 300);
      checks++;
      if (valid_out !== 1'b1 || pc_out !== target || instruction_out !== 14'h100 + {6'b0, target}) begin
         failures++;
         $display("FAIL reach_pc: got v=%0b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                  valid_out, pc_out, instruction_out, target, 14'h100 + {6'b0, target});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h33;
      repeat (2) tick();
      checks++;
      if (valid_out !== 1'b0 || instruction_out !== '0 || pc_out !== '0 ||
          halted !== 1'b0 || imem_addr !== 8'h00) begin
         failures++;
         $display("FAIL reset_state: got v=%0b instr=%h pc=%h halted=%0b addr=%h, expected 0 0 0 0 00",
                  valid_out, instruction_out, pc_out, halted, imem_addr);
      end
      $display("txn reset checked");
   endtask

   task automatic test_run();
      exp_t e;
      do_reset();
      for (int i = 0; i < 8; i++) push_exp(8'(i), 14'h100 + 14'(i));
      tick();
      checks++;
      if (valid_out !== 1'b0 || instruction_out !== '0) begin
         failures++;
         $display("FAIL first_edge: got v=%0b instr=%h, expected v=0 instr=0000", valid_out, instruction_out);
      end
      while (sb.size() > 0) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (valid_out !== 1'b1 || pc_out !== e.pc || instruction_out !== e.instr) begin
            failures++;
            $display("FAIL run: got v=%0b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                     valid_out, pc_out, instruction_out, e.pc, e.instr);
         end
         $display("txn run pc=%h instr=%h", pc_out, instruction_out);
      end
   endtask

   task automatic test_stall();
      exp_t e;
      do_reset();
      run_until(8'd5);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid_out !== 1'b1 || pc_out !== 8'd5 || instruction_out !== 14'h105) begin
            failures++;
            $display("FAIL stall_hold: got v=%0b pc=%h instr=%h, expected v=1 pc=05 instr=0105",
                     valid_out, pc_out, instruction_out);
         end
      end
      stall = 1'b0;
      for (int i = 6; i < 9; i++) push_exp(8'(i), 14'h100 + 14'(i));
      while (sb.size() > 0) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (valid_out !== 1'b1 || pc_out !== e.pc || instruction_out !== e.instr) begin
            failures++;
            $display("FAIL stall_resume: got v=%0b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                     valid_out, pc_out, instruction_out, e.pc, e.instr);
         end
         $display("txn stall_resume pc=%h instr=%h", pc_out, instruction_out);
      end
   endtask

   task automatic test_branch();
      exp_t e;
      do_reset();
      run_until(8'd10);
      branch_taken  = 1'b1;
      branch_target = 8'h40;
      tick();
      branch_taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) tick();
         checks++;
         if (valid_out !== 1'b0 || instruction_out !== '0) begin
            failures++;
            $display("FAIL branch_bubble%0d: got v=%0b instr=%h, expected v=0 instr=0000",
                     i, valid_out, instruction_out);
         end
      end
      for (int i = 0; i < 3; i++) push_exp(8'h40 + 8'(i), 14'h140 + 14'(i));
      while (sb.size() > 0) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (valid_out !== 1'b1 || pc_out !== e.pc || instruction_out !== e.instr) begin
            failures++;
            $display("FAIL branch_target: got v=%0b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                     valid_out, pc_out, instruction_out, e.pc, e.instr);
         end
         $display("txn branch pc=%h instr=%h", pc_out, instruction_out);
      end
   endtask

   task automatic test_branch_in_stall();
      exp_t e;
      do_reset();
      run_until(8'd5);
      stall = 1'b1;
      repeat (2) tick();
      checks++;
      if (valid_out !== 1'b1 || pc_out !== 8'd5) begin
         failures++;
         $display("FAIL bstall_hold: got v=%0b pc=%h, expected v=1 pc=05", valid_out, pc_out);
      end
      branch_taken  = 1'b1;
      branch_target = 8'h20;
      tick();
      branch_taken = 1'b0;
      stall        = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) tick();
         checks++;
         if (valid_out !== 1'b0 || instruction_out !== '0) begin
            failures++;
            $display("FAIL bstall_bubble%0d: got v=%0b instr=%h, expected v=0 instr=0000",
                     i, valid_out, instruction_out);
         end
      end
      push_exp(8'h20, 14'h120);
      push_exp(8'h21, 14'h121);
      while (sb.size() > 0) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (valid_out !== 1'b1 || pc_out !== e.pc || instruction_out !== e.instr) begin
            failures++;
            $display("FAIL bstall_target: got v=%0b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                     valid_out, pc_out, instruction_out, e.pc, e.instr);
         end
         $display("txn branch_in_stall pc=%h instr=%h", pc_out, instruction_out);
      end
   endtask

   task automatic test_halt();
      exp_t e;
      mem[3] = 14'h3C00;
      do_reset();
      tick();
      for (int i = 0; i < 3; i++) push_exp(8'(i), 14'h100 + 14'(i));
      push_exp(8'd3, 14'h3C00);
      while (sb.size() > 0) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (valid_out !== 1'b1 || pc_out !== e.pc || instruction_out !== e.instr || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_pre: got v=%0b pc=%h instr=%h halted=%0b, expected v=1 pc=%h instr=%h halted=0",
                     valid_out, pc_out, instruction_out, halted, e.pc, e.instr);
         end
         $display("txn halt_pre pc=%h instr=%h", pc_out, instruction_out);
      end
      tick();
      checks++;
      if (valid_out !== 1'b0 || instruction_out !== '0 || halted !== 1'b1) begin
         failures++;
         $display("FAIL halt_enter: got v=%0b instr=%h halted=%0b, expected v=0 instr=0000 halted=1",
                  valid_out, instruction_out, halted);
      end
      for (int i = 0; i < 6; i++) begin
         stall         = 1'($urandom_range(0, 1));
         branch_taken  = 1'(i % 2);
         branch_target = 8'h80;
         tick();
         checks++;
         if (valid_out !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'd5) begin
            failures++;
            $display("FAIL halt_stay: got v=%0b halted=%0b addr=%h, expected v=0 halted=1 addr=05",
                     valid_out, halted, imem_addr);
         end
      end
      stall = 1'b0; branch_taken = 1'b0;
      rst_n = 1'b0;
      tick();
      checks++;
      if (halted !== 1'b0 || valid_out !== 1'b0 || imem_addr !== 8'h00) begin
         failures++;
         $display("FAIL halt_reset: got halted=%0b v=%0b addr=%h, expected halted=0 v=0 addr=00",
                  halted, valid_out, imem_addr);
      end
      rst_n  = 1'b1;
      mem[3] = 14'h103;
   endtask

   task automatic test_wrap();
      exp_t e;
      rst_n2 = 1'b0;
      repeat (2) tick();
      rst_n2 = 1'b1;
      tick();
      checks++;
      if (valid_out2 !== 1'b0) begin
         failures++;
         $display("FAIL wrap_first_edge: got v=%0b, expected v=0", valid_out2);
      end
      push_exp(8'hFE, 14'h2FE);
      push_exp(8'hFF, 14'h2FF);
      push_exp(8'h00, 14'h200);
      push_exp(8'h01, 14'h201);
      while (sb.size() > 0) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (valid_out2 !== 1'b1 || pc_out2 !== e.pc || instruction_out2 !== e.instr) begin
            failures++;
            $display("FAIL wrap: got v=%0b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                     valid_out2, pc_out2, instruction_out2, e.pc, e.instr);
         end
         $display("txn wrap pc=%h instr=%h", pc_out2, instruction_out2);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 14'h100 + 14'(i);
      rst_n = 1'b0; rst_n2 = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      test_reset();
      test_run();
      test_stall();
      test_branch();
      test_branch_in_stall();
      test_halt();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
